// File: rtl/sum_latch_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : sum_latch_uart_tx
// Description : Latches two DATA_W-bit operands on active-low save strobes,
//               forms A+B or A-B at frame start and sends the result over an
//               8N1 UART, LSB byte first, as ceil((DATA_W+1)/8) bytes.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module sum_latch_uart_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_a_n,
  input  logic              save_b_n,
  input  logic [DATA_W-1:0] data_input,
  input  logic              op_sub,
  input  logic              uart_tx_en,
  output logic              uart_busy,
  output logic              uart_txd
);

  localparam int c_nbytes = (DATA_W + 8) / 8;
  localparam int c_res_w  = c_nbytes * 8;
  localparam int c_cnt_w  = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_baud_max  = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [1:0]         c_last_byte = 2'(c_nbytes - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic [1:0]        r_sa_sync, r_sb_sync, r_en_sync;
  logic              r_sa_prev, r_sb_prev, r_en_prev;
  logic [DATA_W-1:0] r_a, r_b;
  state_t            r_state, w_state_next;
  logic [c_cnt_w-1:0] r_baud, w_baud_next;
  logic [2:0]        r_bit, w_bit_next;
  logic [1:0]        r_byte, w_byte_next;
  logic [c_res_w-1:0] r_frame, w_frame_next;
  logic              r_txd, r_busy, w_txd_next, w_busy_next;

  logic              w_a_fall, w_b_fall, w_start, w_baud_wrap;
  logic [DATA_W:0]   w_sum, w_diff, w_res;
  logic [c_res_w-1:0] w_res_ext;

  // Pad synchronisers and edge-detect history; strobes idle high, enable idles low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sa_sync <= 2'b11;
      r_sb_sync <= 2'b11;
      r_en_sync <= 2'b00;
      r_sa_prev <= 1'b1;
      r_sb_prev <= 1'b1;
      r_en_prev <= 1'b0;
    end else begin
      r_sa_sync <= {r_sa_sync[0], save_a_n};
      r_sb_sync <= {r_sb_sync[0], save_b_n};
      r_en_sync <= {r_en_sync[0], uart_tx_en};
      r_sa_prev <= r_sa_sync[1];
      r_sb_prev <= r_sb_sync[1];
      r_en_prev <= r_en_sync[1];
    end
  end

  assign w_a_fall    = r_sa_prev & ~r_sa_sync[1];
  assign w_b_fall    = r_sb_prev & ~r_sb_sync[1];
  assign w_start     = r_en_sync[1] & ~r_en_prev;
  assign w_baud_wrap = (r_baud == c_baud_max);

  // Operand registers; the frame snapshot below reads the pre-update values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (w_a_fall) r_a <= data_input;
      if (w_b_fall) r_b <= data_input;
    end
  end

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};
  assign w_res  = op_sub ? w_diff : w_sum;

  // Widen the result to whole bytes: sign-extend differences, zero-extend sums
  generate
    if (c_res_w > DATA_W + 1) begin : g_ext
      assign w_res_ext = {{(c_res_w - DATA_W - 1){op_sub & w_res[DATA_W]}}, w_res};
    end else begin : g_no_ext
      assign w_res_ext = w_res;
    end
  endgenerate

  // FSM and datapath state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_frame <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_byte  <= w_byte_next;
      r_frame <= w_frame_next;
      r_txd   <= w_txd_next;
      r_busy  <= w_busy_next;
    end
  end

  // Next-state logic; the frame register shifts right once per data bit so
  // the next byte lands at the bottom after each 8 bits
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_byte_next  = r_byte;
    w_frame_next = r_frame;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = ST_START;
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_byte_next  = '0;
          w_frame_next = w_res_ext;
        end
      end
      ST_START: begin
        if (w_baud_wrap) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = ST_DATA;
        end else begin
          w_baud_next = r_baud + c_cnt_w'(1);
        end
      end
      ST_DATA: begin
        if (w_baud_wrap) begin
          w_baud_next  = '0;
          w_frame_next = r_frame >> 1;
          if (r_bit == 3'd7) begin
            w_state_next = ST_STOP;
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end else begin
          w_baud_next = r_baud + c_cnt_w'(1);
        end
      end
      ST_STOP: begin
        if (w_baud_wrap) begin
          w_baud_next = '0;
          if (r_byte == c_last_byte) begin
            w_state_next = ST_IDLE;
          end else begin
            w_byte_next  = r_byte + 2'd1;
            w_state_next = ST_START;
          end
        end else begin
          w_baud_next = r_baud + c_cnt_w'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    case (w_state_next)
      ST_START: w_txd_next = 1'b0;
      ST_DATA:  w_txd_next = w_frame_next[0];
      default:  w_txd_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != ST_IDLE);
  end

  assign uart_txd  = r_txd;
  assign uart_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sum_latch_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_latch_uart_tx
// Description : Directed bench for sum_latch_uart_tx with a 4-bit and a
//               12-bit instance, both at 4 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_latch_uart_tx;

  localparam int C = 4;

  logic clk = 1'b0;
  logic reset;
  logic sa4, sb4, en4, op4, busy4, txd4;
  logic [3:0] d4;
  logic sa12, sb12, en12, op12, busy12, txd12;
  logic [11:0] d12;

  int sel = 0;
  int n_cmp = 0;
  int n_fail = 0;
  logic busy_s, txd_s;

  always #5 clk = ~clk;

  assign busy_s = (sel == 1) ? busy12 : busy4;
  assign txd_s  = (sel == 1) ? txd12  : txd4;

  sum_latch_uart_tx #(.DATA_W(4), .CLKS_PER_BIT(C)) dut4 (
    .clk(clk), .reset(reset), .save_a_n(sa4), .save_b_n(sb4),
    .data_input(d4), .op_sub(op4), .uart_tx_en(en4),
    .uart_busy(busy4), .uart_txd(txd4)
  );

  sum_latch_uart_tx #(.DATA_W(12), .CLKS_PER_BIT(C)) dut12 (
    .clk(clk), .reset(reset), .save_a_n(sa12), .save_b_n(sb12),
    .data_input(d12), .op_sub(op12), .uart_tx_en(en12),
    .uart_busy(busy12), .uart_txd(txd12)
  );

  typedef struct {
    int          sel;
    bit          both;
    logic [11:0] a;
    logic [11:0] b;
    bit          op;
    logic [15:0] exp;
    int          nb;
  } vec_t;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic strobe(input bit do_a, input bit do_b, input logic [11:0] v);
    if (sel == 0) d4 = v[3:0]; else d12 = v;
    tick(1);
    if (sel == 0) begin sa4 = ~do_a; sb4 = ~do_b; end
    else begin sa12 = ~do_a; sb12 = ~do_b; end
    tick(4);
    if (sel == 0) begin sa4 = 1'b1; sb4 = 1'b1; end
    else begin sa12 = 1'b1; sb12 = 1'b1; end
    tick(4);
  endtask

  task automatic set_op(input bit op);
    if (sel == 0) op4 = op; else op12 = op;
  endtask

  task automatic pulse_en();
    if (sel == 0) en4 = 1'b1; else en12 = 1'b1;
    tick(2);
    if (sel == 0) en4 = 1'b0; else en12 = 1'b0;
  endtask

  // Waits for busy, then samples txd mid-bit for every busy cycle.
  // inject: raise tx_en mid-frame (left high) and save A=1 during the frame.
  task automatic recv(input int nb, input bit inject, output logic [15:0] val,
                      output int blen, output bit fok, output bit rose);
    int slot, byt, total;
    total = nb * 10 * C;
    val = '0; fok = 1'b1; blen = 0; rose = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (busy_s === 1'b1) begin rose = 1'b1; break; end
      tick(1);
    end
    if (!rose) return;
    while (busy_s === 1'b1 && blen < total + 20) begin
      if ((blen % C) == C / 2 && blen < total) begin
        slot = (blen / C) % 10;
        byt  = blen / (10 * C);
        if (slot == 0) begin
          if (txd_s !== 1'b0) fok = 1'b0;
        end else if (slot == 9) begin
          if (txd_s !== 1'b1) fok = 1'b0;
        end else begin
          val[byt * 8 + slot - 1] = txd_s;
        end
      end
      if (inject) begin
        if (blen == 8)  en4 = 1'b1;
        if (blen == 12) begin d4 = 4'd1; sa4 = 1'b0; end
        if (blen == 20) sa4 = 1'b1;
      end
      blen++;
      tick(1);
    end
  endtask

  task automatic frame_check(input string name, input int nb, input bit inject,
                             input logic [15:0] exp);
    logic [15:0] val;
    int blen;
    bit fok, rose;
    pulse_en();
    recv(nb, inject, val, blen, fok, rose);
    chk({name, "_data"}, val, exp);
    chk({name, "_busy_len"}, blen, nb * 10 * C);
    chk({name, "_framing"}, {rose, fok}, 2'b11);
    tick(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int bad;
    bit rose;

    vecs[0] = '{0, 1'b0, 12'h009, 12'h00C, 1'b0, 16'h0015, 1};
    vecs[1] = '{0, 1'b0, 12'h003, 12'h005, 1'b1, 16'h00FE, 1};
    vecs[2] = '{0, 1'b0, 12'h005, 12'h003, 1'b1, 16'h0002, 1};
    vecs[3] = '{0, 1'b0, 12'h00F, 12'h00F, 1'b0, 16'h001E, 1};
    vecs[4] = '{0, 1'b0, 12'h000, 12'h00F, 1'b1, 16'h00F1, 1};
    vecs[5] = '{0, 1'b1, 12'h007, 12'h000, 1'b0, 16'h000E, 1};
    vecs[6] = '{1, 1'b0, 12'hFFF, 12'hFFF, 1'b0, 16'h1FFE, 2};
    vecs[7] = '{1, 1'b0, 12'h000, 12'hFFF, 1'b1, 16'hF001, 2};
    vecs[8] = '{1, 1'b0, 12'h123, 12'h456, 1'b0, 16'h0579, 2};
    vecs[9] = '{1, 1'b0, 12'h7FF, 12'h800, 1'b1, 16'hFFFF, 2};

    reset = 1'b1;
    sa4 = 1'b1; sb4 = 1'b1; en4 = 1'b0; op4 = 1'b0; d4 = '0;
    sa12 = 1'b1; sb12 = 1'b1; en12 = 1'b0; op12 = 1'b0; d12 = '0;
    tick(3);
    chk("reset_state", {busy4, txd4, busy12, txd12}, 4'b0101);
    reset = 1'b0;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (!(txd4 === 1'b1 && busy4 === 1'b0 && txd12 === 1'b1 && busy12 === 1'b0)) bad++;
    end
    chk("idle_50", bad, 0);

    sel = 0;
    frame_check("post_reset", 1, 1'b0, 16'h0000);

    for (int i = 0; i < 10; i++) begin
      sel = vecs[i].sel;
      if (vecs[i].both) begin
        strobe(1'b1, 1'b1, vecs[i].a);
      end else begin
        strobe(1'b1, 1'b0, vecs[i].a);
        strobe(1'b0, 1'b1, vecs[i].b);
      end
      set_op(vecs[i].op);
      frame_check($sformatf("vec%0d", i), vecs[i].nb, 1'b0, vecs[i].exp);
    end

    // Mid-frame tx_en edge (held high afterwards) and save_a during the frame
    sel = 0;
    strobe(1'b1, 1'b0, 12'h009);
    strobe(1'b0, 1'b1, 12'h00C);
    set_op(1'b0);
    frame_check("midframe", 1, 1'b1, 16'h0015);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy4 !== 1'b0) bad++;
      tick(1);
    end
    chk("no_retrigger", bad, 0);
    en4 = 1'b0;
    tick(4);
    frame_check("new_a_used", 1, 1'b0, 16'h000D);

    // Reset during DATA bit 3 of 0x15 (bit 3 is 0)
    strobe(1'b1, 1'b0, 12'h009);
    pulse_en();
    rose = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (busy4 === 1'b1) begin rose = 1'b1; break; end
      tick(1);
    end
    chk("rst_busy_rise", rose, 1'b1);
    tick(17);
    chk("rst_pre", {busy4, txd4}, 2'b10);
    reset = 1'b1;
    #1;
    chk("rst_async", {busy4, txd4}, 2'b01);
    tick(1);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!(txd4 === 1'b1 && busy4 === 1'b0)) bad++;
    end
    chk("rst_idle_after", bad, 0);
    strobe(1'b1, 1'b0, 12'h006);
    strobe(1'b0, 1'b1, 12'h002);
    frame_check("after_reset", 1, 1'b0, 16'h0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
